// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32 x WIDTH architectural register file, two combinational read ports, one write port.
// Defining REGFILE_BYPASS_EN adds a same-cycle write-through bypass on both read ports.
module regfile_2r1w #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_writeEnable,
    input  logic [4:0]       ctrl_writeReg,
    input  logic [WIDTH-1:0] data_writeReg,
    input  logic [4:0]       ctrl_readRegA,
    input  logic [4:0]       ctrl_readRegB,
    output logic [WIDTH-1:0] data_readRegA,
    output logic [WIDTH-1:0] data_readRegB
);

    logic [31:0]      write_sel;
    logic [WIDTH-1:0] regs_d   [1:31];
    logic [WIDTH-1:0] regs_q   [1:31];
    logic [WIDTH-1:0] reg_view [0:31];
    logic [WIDTH-1:0] read_a;
    logic [WIDTH-1:0] read_b;

    // One-hot write-select decoder; bit 0 exists but has no register behind it.
    always_comb begin
        write_sel = 32'd1 << ctrl_writeReg;
    end

    // NOTE: every path assigns regs_d, so no latch is inferred; next-state logic uses blocking '='.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = (ctrl_writeEnable && write_sel[i]) ? data_writeReg : regs_q[i];
        end
    end

    // NOTE: this array is reset because its contents are architecturally visible, unlike a scratch RAM;
    // sequential state is updated with non-blocking '<=' only.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        reg_view[0] = '0;
        for (int i = 1; i < 32; i++) begin
            reg_view[i] = regs_q[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic bypass_a;
    logic bypass_b;

    // Forward the in-flight write so a same-cycle reader sees the new value; r0 never forwards.
    always_comb begin
        bypass_a = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA) && (ctrl_readRegA != 5'd0);
        bypass_b = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB) && (ctrl_readRegB != 5'd0);
        read_a   = bypass_a ? data_writeReg : reg_view[ctrl_readRegA];
        read_b   = bypass_b ? data_writeReg : reg_view[ctrl_readRegB];
    end
`else
    always_comb begin
        read_a = reg_view[ctrl_readRegA];
        read_b = reg_view[ctrl_readRegB];
    end
`endif

    // Outputs are forced low during reset so a bypassed write cannot leak through.
    assign data_readRegA = ctrl_reset_n ? read_a : '0;
    assign data_readRegB = ctrl_reset_n ? read_b : '0;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: stimulus pushes expected read data, a monitor pops and compares.
// Expected values come from a plain array model of the 32 architectural registers.
module tb_regfile_2r1w;

    localparam int WIDTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clock;
    logic             ctrl_reset_n;
    logic             ctrl_writeEnable;
    logic [4:0]       ctrl_writeReg;
    logic [WIDTH-1:0] data_writeReg;
    logic [4:0]       ctrl_readRegA;
    logic [4:0]       ctrl_readRegB;
    logic [WIDTH-1:0] data_readRegA;
    logic [WIDTH-1:0] data_readRegB;

    regfile_2r1w #(.WIDTH(WIDTH)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;
        logic [4:0]       addr_a;
        logic [4:0]       addr_b;
        string            tag;
    } exp_t;

    exp_t             sb_q[$];
    event             sample_ev;
    int               n_compared = 0;
    int               n_mismatch = 0;
    logic [WIDTH-1:0] model [32];

    // Architectural view of a read: reset gives 0, r0 gives 0, optional same-cycle forwarding.
    function automatic logic [WIDTH-1:0] expect_read(input logic [4:0] addr);
        if (!ctrl_reset_n) return '0;
        if (addr == 5'd0) return '0;
        if (BYPASS && ctrl_writeEnable && (ctrl_writeReg == addr)) return data_writeReg;
        return model[addr];
    endfunction

    task automatic drive(input logic en, input logic [4:0] wa, input logic [WIDTH-1:0] wd,
                         input logic [4:0] a, input logic [4:0] b);
        ctrl_writeEnable = en;
        ctrl_writeReg    = wa;
        data_writeReg    = wd;
        ctrl_readRegA    = a;
        ctrl_readRegB    = b;
    endtask

    task automatic sample(input string tag);
        exp_t e;
        e.exp_a  = expect_read(ctrl_readRegA);
        e.exp_b  = expect_read(ctrl_readRegB);
        e.addr_a = ctrl_readRegA;
        e.addr_b = ctrl_readRegB;
        e.tag    = tag;
        sb_q.push_back(e);
        -> sample_ev;
        #2;
    endtask

    // Advance through one rising edge, commit it to the model, and return on the following falling edge.
    task automatic clock_edge();
        @(posedge clock);
        if (ctrl_reset_n && ctrl_writeEnable && (ctrl_writeReg != 5'd0)) model[ctrl_writeReg] = data_writeReg;
        @(negedge clock);
    endtask

    task automatic read_at(input logic [4:0] a, input logic [4:0] b, input string tag);
        drive(1'b0, 5'd0, '0, a, b);
        sample(tag);
        @(negedge clock);
    endtask

    task automatic check(input exp_t e);
        n_compared++;
        if ((data_readRegA !== e.exp_a) || (data_readRegB !== e.exp_b)) begin
            n_mismatch++;
            $display("FAIL %s @%0t: A[%0d]=%h B[%0d]=%h, required A=%h B=%h",
                     e.tag, $time, e.addr_a, data_readRegA, e.addr_b, data_readRegB, e.exp_a, e.exp_b);
        end
    endtask

    // Monitor: read outputs are combinational, so each sample request is compared 1 time unit later.
    initial begin
        forever begin
            exp_t e;
            @(sample_ev);
            #1;
            if (sb_q.size() == 0) begin
                n_mismatch++;
                $display("FAIL scoreboard_underflow @%0t: no expected entry queued", $time);
            end else begin
                e = sb_q.pop_front();
                check(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, compared=%0d", n_compared);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]       wa;
        logic [4:0]       ra;
        logic [4:0]       rb;
        logic [WIDTH-1:0] wd;

        for (int i = 0; i < 32; i++) model[i] = '0;
        ctrl_reset_n = 1'b0;
        drive(1'b1, 5'd3, 32'h1234_5678, 5'd0, 5'd0);
        @(negedge clock);

        // Reset held: sweep both ports while writes are attempted every edge.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i), $urandom, 5'(i), 5'(31 - i));
            sample("reset_sweep");
            clock_edge();
        end
        drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
        ctrl_reset_n = 1'b1;
        @(negedge clock);

        // Load every register; pre-edge sample also exercises same-cycle reads of the target.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'h1000_0000 + 32'(i), 5'(i), 5'(i - 1));
            sample("write_all_pre_edge");
            clock_edge();
        end
        for (int i = 0; i < 32; i++) read_at(5'(i), 5'(31 - i), "read_all");

        // Writes to r0 are discarded and leave r1 untouched.
        drive(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd1);
        sample("r0_write_pre_edge");
        clock_edge();
        read_at(5'd0, 5'd1, "r0_protect");

        // Enable low: reg 5 keeps its value.
        drive(1'b0, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5);
        sample("enable_gate_pre_edge");
        clock_edge();
        read_at(5'd5, 5'd5, "enable_gate");

        // Same-cycle write/read hazard on reg 7.
        drive(1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd3);
        sample("hazard_pre_edge");
        clock_edge();
        read_at(5'd7, 5'd7, "hazard_post_edge");

        // Random traffic, biased so reads often hit the write address.
        for (int n = 0; n < 300; n++) begin
            wa = 5'($urandom);
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            if ($urandom_range(0, 15) == 0) wa = 5'd0;
            drive(1'($urandom), wa, wd, ra, rb);
            sample("random");
            clock_edge();
        end

        // Asynchronous reset pulse between edges.
        drive(1'b0, 5'd0, '0, 5'd7, 5'd1);
        #2;
        ctrl_reset_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        sample("async_reset_low");
        ctrl_reset_n = 1'b1;
        clock_edge();
        for (int i = 0; i < 32; i++) read_at(5'(i), 5'(31 - i), "after_async_reset");

        // Writes resume after reset.
        wd = $urandom;
        drive(1'b1, 5'd9, wd, 5'd9, 5'd9);
        clock_edge();
        read_at(5'd9, 5'd0, "write_resume");

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) #1;
        if (sb_q.size() != 0) begin
            n_mismatch++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
